// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants
// and the 2-of-3 vote used by the UART_RX_MAJORITY_EN build.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } uart_state_e;

   localparam int unsigned OVS               = 16;
   localparam int unsigned OVS_DIV_9600_100M = 651;
   localparam int unsigned DATA_BITS         = 8;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_ovs_tick.sv
// Free-running oversample tick generator: one-clk pulse every DIV clocks.
module uart_ovs_tick #(
   parameter int unsigned DIV = 651
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned    W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]   LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      tick  = (cnt_q == LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling. Define UART_RX_MAJORITY_EN to make
// every bit decision a 2-of-3 vote over three adjacent oversample ticks.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned OVS_DIV = OVS_DIV_9600_100M
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RxD,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 rx_busy
);

   localparam int unsigned BW        = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_TICK = 4'(OVS - 1);

   // Voting decides one tick later than single sampling; entering the next bit
   // at count 1 keeps the sample instants identical in both builds.
`ifdef UART_RX_MAJORITY_EN
   localparam logic [3:0] START_DECIDE = 4'(OVS / 2);
   localparam logic [3:0] BIT_DECIDE   = 4'd0;
   localparam logic [3:0] ENTRY_CNT    = 4'd1;
`else
   localparam logic [3:0] START_DECIDE = 4'(OVS / 2 - 1);
   localparam logic [3:0] BIT_DECIDE   = LAST_TICK;
   localparam logic [3:0] ENTRY_CNT    = 4'd0;
`endif

   logic tick;

   uart_ovs_tick #(.DIV(OVS_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   uart_state_e          state_q, state_d;
   logic                 sync1_q, rxs_q;
   logic [3:0]           tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] sr_q, sr_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 bit_val;
`ifdef UART_RX_MAJORITY_EN
   logic [1:0]           samp_q, samp_d;
   logic                 samp_pt;
`endif

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      sr_d        = sr_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_MAJORITY_EN
      samp_d  = samp_q;
      bit_val = maj3(samp_q[1], samp_q[0], rxs_q);
      if (state_q == S_START)
         samp_pt = (tick_cnt_q == START_DECIDE - 4'd2) || (tick_cnt_q == START_DECIDE - 4'd1);
      else
         samp_pt = (tick_cnt_q == LAST_TICK - 4'd1) || (tick_cnt_q == LAST_TICK);
      if (tick && samp_pt) samp_d = {samp_q[0], rxs_q};
`else
      bit_val = rxs_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (tick && !rxs_q) begin
               tick_cnt_d = '0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == START_DECIDE) begin
                  if (!bit_val) begin
                     tick_cnt_d = ENTRY_CNT;
                     bit_cnt_d  = '0;
                     state_d    = S_DATA;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == BIT_DECIDE) begin
                  sr_d      = {bit_val, sr_q[DATA_BITS-1:1]};
                  bit_cnt_d = bit_cnt_q + BW'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     tick_cnt_d = ENTRY_CNT;
                     state_d    = S_STOP;
                  end
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 4'd1;
               if (tick_cnt_q == BIT_DECIDE) begin
                  if (bit_val) begin
                     rx_data_d  = sr_q;
                     rx_valid_d = 1'b1;
                     state_d    = S_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = S_BREAK;
                  end
               end
            end
         end
         S_BREAK: begin
            if (tick && rxs_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q     <= 1'b1;
         rxs_q       <= 1'b1;
         state_q     <= S_IDLE;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         sr_q        <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         samp_q      <= '0;
`endif
      end else begin
         sync1_q     <= RxD;
         rxs_q       <= sync1_q;
         state_q     <= state_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         sr_q        <= sr_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
`ifdef UART_RX_MAJORITY_EN
         samp_q      <= samp_d;
`endif
      end
   end

   always_comb begin
      rx_data   = rx_data_q;
      rx_valid  = rx_valid_q;
      frame_err = frame_err_q;
      rx_busy   = (state_q != S_IDLE);
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx (OVS_DIV=4, 64 clk per bit);
// the serial line is driven by a behavioural 8N1 transmitter.
module tb_uart_rx;

   localparam int BIT_CLKS = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       RxD;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       rx_busy;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int         ferr_cnt = 0;
   int         both_cnt = 0;
   logic [7:0] last_good = 8'h00;

   uart_rx #(.OVS_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .RxD       (RxD),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   // Record every output pulse, sampled away from the active edge.
   always @(negedge clk) begin
      if (rx_valid) got_q.push_back(rx_data);
      if (frame_err) ferr_cnt++;
      if (rx_valid && frame_err) both_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      RxD = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      hold(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) hold(b[i], BIT_CLKS);
      hold(stop_v, BIT_CLKS);
   endtask

   // Inverts the line for one tick period exactly at the centre sample of each bit.
   task automatic send_frame_glitched(input logic [7:0] b);
      logic [9:0] bits;
      bits = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         hold(bits[i], 32);
         hold(~bits[i], 4);
         hold(bits[i], 28);
      end
   endtask

   task automatic cmp_frames(input string tag);
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [7:0] b;
      int         gap;
      int         hit96;

      rst = 1'b0;
      RxD = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_data",  32'(rx_data),   32'h00);
      chk("rst_valid", 32'(rx_valid),  32'h0);
      chk("rst_ferr",  32'(frame_err), 32'h0);
      chk("rst_busy",  32'(rx_busy),   32'h0);
      rst = 1'b1;
      hold(1'b1, 2 * BIT_CLKS);

      // Two frames with zero idle time between them.
      send_frame(8'hA5, 1'b1);
      send_frame(8'h3C, 1'b1);
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      last_good = 8'h3C;
      hold(1'b1, BIT_CLKS);
      cmp_frames("pair");
      chk("pair_ferr", 32'(ferr_cnt), 32'h0);
      chk("pair_data", 32'(rx_data), 32'(last_good));

      // Random bytes with random 0..2 bit idle gaps.
      for (int n = 0; n < 12; n++) begin
         b   = 8'($urandom);
         gap = int'($urandom_range(0, 2));
         send_frame(b, 1'b1);
         exp_q.push_back(b);
         last_good = b;
         if (gap > 0) hold(1'b1, gap * BIT_CLKS);
      end
      hold(1'b1, BIT_CLKS);
      cmp_frames("rand");
      chk("rand_ferr", 32'(ferr_cnt), 32'h0);
      chk("rand_data", 32'(rx_data), 32'(last_good));

      // Five-tick low glitch while idle: start seen, then rejected.
      hold(1'b0, 20);
      chk("glitch_busy", 32'(rx_busy), 32'h1);
      hold(1'b1, 40);
      chk("glitch_idle", 32'(rx_busy), 32'h0);
      hold(1'b1, BIT_CLKS);
      cmp_frames("glitch");
      chk("glitch_ferr", 32'(ferr_cnt), 32'h0);

      // Stop bit low for one bit, then line recovers.
      send_frame(8'h55, 1'b0);
      hold(1'b1, BIT_CLKS);
      chk("ferr_count", 32'(ferr_cnt), 32'h1);
      chk("ferr_data", 32'(rx_data), 32'(last_good));
      cmp_frames("ferr_none");
      send_frame(8'h0F, 1'b1);
      exp_q.push_back(8'h0F);
      last_good = 8'h0F;
      hold(1'b1, BIT_CLKS);
      cmp_frames("ferr_next");
      chk("ferr_once", 32'(ferr_cnt), 32'h1);
      ferr_cnt = 0;

      // Line held low for 30 bit times.
      hold(1'b0, 20 * BIT_CLKS);
      chk("brk_busy", 32'(rx_busy), 32'h1);
      hold(1'b0, 10 * BIT_CLKS);
      chk("brk_ferr", 32'(ferr_cnt), 32'h1);
      chk("brk_data", 32'(rx_data), 32'(last_good));
      hold(1'b1, 2 * BIT_CLKS);
      chk("brk_exit", 32'(rx_busy), 32'h0);
      send_frame(8'hC3, 1'b1);
      exp_q.push_back(8'hC3);
      last_good = 8'hC3;
      hold(1'b1, BIT_CLKS);
      cmp_frames("brk_next");
      chk("brk_ferr_once", 32'(ferr_cnt), 32'h1);
      ferr_cnt = 0;

      // One-clock reset in the middle of data bit 4 of 8'hFF.
      hold(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) hold(1'b1, BIT_CLKS);
      hold(1'b1, 32);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      last_good = 8'h00;
      chk("abort_data",  32'(rx_data),   32'h00);
      chk("abort_valid", 32'(rx_valid),  32'h0);
      chk("abort_ferr",  32'(frame_err), 32'h0);
      chk("abort_busy",  32'(rx_busy),   32'h0);
      hold(1'b1, 32 + 4 * BIT_CLKS);
      hold(1'b1, BIT_CLKS);
      cmp_frames("abort_none");
      send_frame(8'h81, 1'b1);
      exp_q.push_back(8'h81);
      last_good = 8'h81;
      hold(1'b1, BIT_CLKS);
      cmp_frames("abort_next");
      chk("abort_next_data", 32'(rx_data), 32'(last_good));
      chk("abort_ferr_cnt", 32'(ferr_cnt), 32'h0);

      // Centre-sample glitches on every bit of 8'h96.
      send_frame_glitched(8'h96);
      hold(1'b1, 2 * BIT_CLKS);
`ifdef UART_RX_MAJORITY_EN
      exp_q.push_back(8'h96);
      cmp_frames("maj");
      chk("maj_ferr", 32'(ferr_cnt), 32'h0);
`else
      hit96 = 0;
      foreach (got_q[i]) if (got_q[i] == 8'h96) hit96++;
      chk("nomaj_no96", 32'(hit96), 32'h0);
      got_q.delete();
`endif

      chk("no_overlap", 32'(both_cnt), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver. Consumes the serial line driven by the codebase's existing UART transmitter, uart_tx_FSM (TxD).
- Recovers 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Uses 16x oversampling from an internal tick generator.
- Presents each received byte as a one-cycle valid pulse to the downstream user logic, e.g. LEDs or a FIFO.

Parameters:
- OVS_DIV, 651, clk cycles per oversample tick. 100 MHz / (9600 x 16) ≈ 651. Minimum 2; benches may use 4.
- OVS, 16, oversample ticks per bit. Fixed at 16; exposed for the package only.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset, synchronous, active-low. Sampled on the rising edge of clk; 0 = reset.
- RxD  in  1  asynchronous serial input; idle high.
- rx_data  out  8  last correctly framed byte.
- rx_valid  out  1  one-clk pulse when rx_data is updated.
- frame_err  out  1  one-clk pulse when the stop bit is sampled low.
- rx_busy  out  1  high while state != IDLE.

Behaviour:
- Reset values (rst=0 at a clk edge):
  - rx_data=8'h00, rx_valid=0, frame_err=0, rx_busy=0.
  - Synchronizer flops = 1, state=IDLE, all counters = 0.
  - Reset mid-frame aborts the frame with no pulse. Reception resumes only on a new falling edge after rst=1.
- Input synchronizer: 2 flops on RxD → rxs. Everything below uses rxs only.
- Tick generator: free-running modulo-OVS_DIV counter; tick = 1 for one clk when it wraps. It is never gated by state.
- Counters:
  - tick_cnt is 4-bit and counts ticks within a bit.
  - bit_cnt is 3-bit and counts data bits.
- IDLE:
  - Wait for rxs=0 on a tick.
  - On that tick: tick_cnt←0, go to START.
- START:
  - On each tick, tick_cnt++.
  - At tick_cnt==7 (mid start bit):
    - rxs=0 → tick_cnt←0, bit_cnt←0, go to DATA.
    - rxs=1 → false start (glitch), go to IDLE with no pulse.
- DATA:
  - On each tick, tick_cnt++.
  - At tick_cnt==15, shift the sample into the MSB of shift register sr (sr←{bit,sr[7:1]}), so bits fill LSB-first.
  - After the 8th sample (bit_cnt==7), go to STOP with tick_cnt←0.
- STOP, at tick_cnt==15 (mid stop bit):
  - rxs=1 → rx_data←sr and rx_valid=1 on the next clk; go to IDLE.
  - rxs=0 → frame_err=1 on the next clk; rx_data is unchanged; go to BREAK.
- BREAK:
  - Stay until rxs=1 on a tick, then go to IDLE.
  - A held-low line produces exactly one frame_err and no further frames.
- Latency: rx_valid rises ≈9.5 bit times plus 2–3 clk after the start falling edge.
- Back-to-back frames: the return to IDLE at mid stop bit allows a start bit that immediately follows the stop bit to be detected. No frames are lost at 0 idle time.
- No downstream backpressure:
  - rx_valid is a pulse; an unread byte is overwritten by the next frame.
  - rx_valid and frame_err are never high in the same cycle.
- State encoding: 3-bit, IDLE=0, START=1, DATA=2, STOP=3, BREAK=4. Unused codes → IDLE.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit decision (start check, data bits, stop bit) is the 2-of-3 majority of rxs sampled at three ticks: tick_cnt 6, 7, 8 of the start bit, and 14, 15, 0 of the other bits.
  - Transitions occur on the third sample.
  - A single corrupted sample per bit is tolerated.
- Undefined: single sample as specified above.
- The ports are identical in both builds.

Decomposition:
- Package uart_pkg holds:
  - state constants S_IDLE..S_BREAK;
  - OVS=16;
  - OVS_DIV_9600_100M=651;
  - DATA_BITS=8.
- Sub-module uart_ovs_tick (clk, rst, tick; parameter DIV) implements the tick generator. It is reusable by a future oversampled transmitter.

Test Plan:
- Loopback with uart_tx_FSM (OVS_DIV=4, matching baud): send 8'hA5, then 8'h3C → rx_valid pulses twice, rx_data=A5 then 3C, frame_err never 1.
- Glitch: RxD low for 5 ticks during IDLE → no rx_valid, no frame_err, rx_busy returns 0 within 8 ticks.
- Framing error: frame 8'h55 with stop bit forced low for 1 bit, then high → single frame_err pulse, rx_data keeps previous value, next good frame 8'h0F received.
- Break: RxD held low 30 bit times → exactly one frame_err, state BREAK until RxD high. A following frame 8'hC3 is received correctly.
- Reset mid-frame: rst=0 for 1 clk during bit 4 of 8'hFF → all outputs 0 next cycle, no rx_valid for the aborted frame, next frame 8'h81 received.
- Majority (UART_RX_MAJORITY_EN defined): 1-tick glitch inverting the mid-sample of every bit of 8'h96 → rx_data=96. The same stimulus without the macro → mismatch or frame_err.
